// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control decoder.
package alu_pkg;

  // ALUCtrl operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;

  // Execute-unit FSM state type and encodings
  typedef logic [1:0] alu_state_t;
  localparam alu_state_t ST_IDLE = 2'd0;
  localparam alu_state_t ST_MUL  = 2'd1;
  localparam alu_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// Returns the low WIDTH bits of the product (same for signed and unsigned).
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             run;

  // done flags the edge that performs the final iteration
  always_comb begin
    busy    = run;
    done    = run && (cnt == SHW'(WIDTH - 1));
    product = acc;
  end

  // Shift-add datapath and iteration counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle add/sub/slt/sll, iterative mul with Busy
// stall, registered ALUResult/Zero with a one-cycle OutValid pulse.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  input  logic [2:0]       ALUCtrl,
  input  logic             Shift,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  input  logic             Flush,
  output logic             InReady,
  output logic             Busy,
  output logic             OutValid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  alu_state_t       state;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [SHW-1:0]   shamt_sel;
  logic [WIDTH-1:0] single_res;

  // Handshake and single-cycle result; InReady depends on state only
  always_comb begin
    InReady    = (state == ST_IDLE);
    Busy       = (state != ST_IDLE);
    accept     = (state == ST_IDLE) && InValid && !Flush;
    mul_start  = accept && (ALUCtrl == ALU_MUL);
    shamt_sel  = Shift ? Shamt : A[SHW-1:0];
    single_res = '0;
    case (ALUCtrl)
      ALU_ADD: single_res = A + B;
      ALU_SUB: single_res = A - B;
      ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL: single_res = B << shamt_sel;
      default: single_res = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (mul_start),
    .flush   (Flush),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Sequencing FSM and output registers; Flush overrides everything
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      ALUResult <= '0;
      Zero      <= 1'b1;
      OutValid  <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      if (Flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (InValid) begin
              if (ALUCtrl == ALU_MUL) begin
                state <= ST_MUL;
              end else begin
                ALUResult <= single_res;
                Zero      <= (single_res == '0);
                OutValid  <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            if (mul_done) begin
              state <= ST_DONE;
            end else if (!mul_busy) begin
              state <= ST_IDLE;
            end
          end
          ST_DONE: begin
            ALUResult <= mul_product;
            Zero      <= (mul_product == '0);
            OutValid  <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_execute_unit.md
# alu_execute_unit

Execute-stage ALU for the MIPS pipeline. It consumes the 3-bit ALU control code and shift flag from the ALU control decoder, together with the operands from the ID/EX register, and produces a registered result and zero flag for the EX/MEM register. Add, sub, slt and sll complete in one cycle. Mul is an iterative shift-add that takes WIDTH cycles and asserts `Busy` so the hazard unit stalls IF/ID/EX.

## Interface
- `WIDTH`, default 32: datapath width. Mul iteration count equals WIDTH.
- `SHW`, default 5: shift-amount width, log2(WIDTH).

Ports (name, direction, width, meaning):
- `Clk`, in, 1: single clock. Everything is on the rising edge.
- `Rst_n`, in, 1: reset, synchronous, active-low.
- `InValid`, in, 1: the ID/EX stage presents a valid operation.
- `ALUCtrl`, in, 3: operation code. 000 add, 001 sub, 010 slt, 011 mul, 100 sll, 101–111 reserved.
- `Shift`, in, 1: when 1, the sll operand source is `Shamt`.
- `A`, in, WIDTH: rs operand.
- `B`, in, WIDTH: rt operand or sign-extended immediate.
- `Shamt`, in, SHW: instruction shamt field.
- `Flush`, in, 1: abort any in-flight operation (branch/exception squash).
- `InReady`, out, 1: the unit accepts an operation this cycle. Equals !Busy.
- `Busy`, out, 1: a mul is in progress. Drives the pipeline stall.
- `OutValid`, out, 1: one-cycle pulse; `ALUResult` and `Zero` are valid.
- `ALUResult`, out, WIDTH: registered result.
- `Zero`, out, 1: registered flag, (ALUResult == 0).

## Operation
- FSM states: IDLE, MUL, DONE.
- Accept condition: IDLE && InValid && !Flush.
- Single-cycle ops, on the accepting edge:
  - add: A+B, modulo 2^WIDTH.
  - sub: A−B, modulo 2^WIDTH.
  - slt: 1 if signed(A) < signed(B), else 0. Zero-extended to WIDTH.
  - sll: B << (Shift ? Shamt : A[SHW-1:0]).
  - reserved codes: result 0.
  - In all cases `OutValid`=1 next cycle. State stays IDLE.
- Mul, on the accepting edge:
  - Latch multiplicand=A, multiplier=B, acc=0, cnt=0. Go to MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - When cnt reaches WIDTH−1 after its iteration, go to DONE.
  - Result is the low WIDTH bits of the product, which are identical for signed and unsigned operands.
- DONE: load acc into ALUResult, pulse OutValid, return to IDLE. IDLE is able to accept again on the next edge.
- No downstream backpressure. The EX/MEM register samples on OutValid.
- Flush:
  - In MUL or DONE: go to IDLE, no OutValid.
  - With InValid in IDLE: the operation is not accepted.
  - Flush has priority over every other event.
- `ALUResult` and `Zero` hold their last value between pulses.

## Timing
- Reset (Rst_n=0 at an edge): state IDLE, cnt=0, ALUResult=0, Zero=1, OutValid=0, Busy=0, InReady=1.
- Reset mid-mul aborts with no OutValid.
- Single-cycle latency: accept at edge N, OutValid high in the cycle after edge N.
- Mul latency: accept at edge N. Busy is high from after edge N through edge N+WIDTH+1. OutValid is high in the cycle after edge N+WIDTH+1, i.e. WIDTH+1 cycles after a single-cycle op would report.
- InReady is combinational from state only, never from inputs.
- Back-to-back single-cycle ops are accepted every cycle.
- While Busy=1, InValid is ignored. The upstream stage must hold the operation.
- Simultaneous DONE and InValid: the new op is not accepted that cycle; it is accepted on the following IDLE cycle.

## Structure
- Shared package `alu_pkg`:
  - ALUCtrl encodings ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_SLL.
  - FSM state typedef.
  - Also used by the ALU control decoder.
- Sub-module `seq_multiplier`:
  - Holds the shift-add datapath and cnt.
  - Ports: start, flush, a, b, busy, done, product.
  - The top-level FSM sequences it and muxes its product into ALUResult.

## Test plan
- Reset, then add A=0x7FFFFFFF, B=1: ALUResult=0x80000000, Zero=0, OutValid one cycle later.
- sub A=5, B=5: ALUResult=0, Zero=1. Then slt A=0xFFFFFFFF, B=1: ALUResult=1.
- sll with Shift=1, Shamt=4, B=0x0000000F: ALUResult=0x000000F0. Reserved code 101: ALUResult=0, OutValid=1.
- mul A=0xFFFFFFFD (−3), B=7:
  - ALUResult=0xFFFFFFEB.
  - OutValid exactly WIDTH+1 cycles after the accept cycle.
  - Busy high throughout; a concurrent InValid is ignored.
- mul started, Flush asserted at iteration 10: no OutValid, Busy=0 next cycle, and an add issued next is accepted and correct.
- mul started, Rst_n=0 at iteration 20: all outputs take reset values, and a following mul 6×7 yields 42.
